// File: rtl/morse_pkg.sv
// Shared constants and types for the Morse symbol sequencer.
package morse_pkg;

  // Front-end pulse codes (2'b11 is ignored).
  localparam logic [1:0] SIG_NONE = 2'b00;
  localparam logic [1:0] SIG_DOT  = 2'b01;
  localparam logic [1:0] SIG_DASH = 2'b10;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PENDING = 2'd2
  } state_t;

  // Default timing and sizing.
  localparam int unsigned DEF_MAX_SYMBOLS = 5;
  localparam int unsigned DEF_LETTER_GAP  = 3000;
  localparam int unsigned DEF_WORD_GAP    = 7000;
  localparam int unsigned DEF_CNT_W       = 16;

  // Width of the symbol-count field.
  localparam int unsigned LEN_W = 3;

  // Decoder fallback for unknown or overflowed characters ('?').
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

endpackage

// File: rtl/morse_ascii_lut.sv
// Combinational (len, pattern) -> ASCII decoder for A-Z and 0-9.
// Pattern bit i is symbol i (1 = dash); unknown patterns and errors give '?'.
module morse_ascii_lut
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYMBOLS = DEF_MAX_SYMBOLS
) (
  input  logic [LEN_W-1:0]       len,
  input  logic [MAX_SYMBOLS-1:0] bits,
  input  logic                   err,
  output logic [7:0]             ascii_c
);

  logic [7:0] pat_c;

  assign pat_c = 8'(bits);

  // Table lookup keyed first on length, then on the dash pattern.
  always_comb begin
    ascii_c = ASCII_UNKNOWN;
    if (!err) begin
      unique case (len)
        3'd1: begin
          unique case (pat_c)
            8'd0:    ascii_c = 8'h45; // E
            8'd1:    ascii_c = 8'h54; // T
            default: ascii_c = ASCII_UNKNOWN;
          endcase
        end
        3'd2: begin
          unique case (pat_c)
            8'd0:    ascii_c = 8'h49; // I
            8'd1:    ascii_c = 8'h4E; // N
            8'd2:    ascii_c = 8'h41; // A
            8'd3:    ascii_c = 8'h4D; // M
            default: ascii_c = ASCII_UNKNOWN;
          endcase
        end
        3'd3: begin
          unique case (pat_c)
            8'd0:    ascii_c = 8'h53; // S
            8'd1:    ascii_c = 8'h44; // D
            8'd2:    ascii_c = 8'h52; // R
            8'd3:    ascii_c = 8'h47; // G
            8'd4:    ascii_c = 8'h55; // U
            8'd5:    ascii_c = 8'h4B; // K
            8'd6:    ascii_c = 8'h57; // W
            8'd7:    ascii_c = 8'h4F; // O
            default: ascii_c = ASCII_UNKNOWN;
          endcase
        end
        3'd4: begin
          unique case (pat_c)
            8'd0:    ascii_c = 8'h48; // H
            8'd1:    ascii_c = 8'h42; // B
            8'd2:    ascii_c = 8'h4C; // L
            8'd3:    ascii_c = 8'h5A; // Z
            8'd4:    ascii_c = 8'h46; // F
            8'd5:    ascii_c = 8'h43; // C
            8'd6:    ascii_c = 8'h50; // P
            8'd8:    ascii_c = 8'h56; // V
            8'd9:    ascii_c = 8'h58; // X
            8'd11:   ascii_c = 8'h51; // Q
            8'd13:   ascii_c = 8'h59; // Y
            8'd14:   ascii_c = 8'h4A; // J
            default: ascii_c = ASCII_UNKNOWN;
          endcase
        end
        3'd5: begin
          unique case (pat_c)
            8'd31:   ascii_c = 8'h30; // 0
            8'd30:   ascii_c = 8'h31; // 1
            8'd28:   ascii_c = 8'h32; // 2
            8'd24:   ascii_c = 8'h33; // 3
            8'd16:   ascii_c = 8'h34; // 4
            8'd0:    ascii_c = 8'h35; // 5
            8'd1:    ascii_c = 8'h36; // 6
            8'd3:    ascii_c = 8'h37; // 7
            8'd7:    ascii_c = 8'h38; // 8
            8'd15:   ascii_c = 8'h39; // 9
            default: ascii_c = ASCII_UNKNOWN;
          endcase
        end
        default: ascii_c = ASCII_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Groups dot/dash pulses into Morse characters using idle-gap timing and
// presents them on a valid/ready handshake; also flags word gaps and overrun.
// Optional ASCII output (char_ascii) when MORSE_ASCII_DECODE_EN is defined.
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYMBOLS = DEF_MAX_SYMBOLS,
  parameter int unsigned LETTER_GAP  = DEF_LETTER_GAP,
  parameter int unsigned WORD_GAP    = DEF_WORD_GAP,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             morse_signal,
  output logic                   sym_valid,
  input  logic                   sym_ready,
  output logic [LEN_W-1:0]       sym_len,
  output logic [MAX_SYMBOLS-1:0] sym_bits,
  output logic                   sym_err,
  output logic                   word_gap,
  output logic                   overrun,
  output logic                   busy
`ifdef MORSE_ASCII_DECODE_EN
  ,
  output logic [7:0]             char_ascii
`endif
);

  localparam logic [CNT_W-1:0] LG_C    = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WG_C    = CNT_W'(WORD_GAP);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SYMBOLS);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [MAX_SYMBOLS-1:0] bits_q, bits_d;
  logic                   err_q, err_d;
  logic                   armed_q, armed_d;

  logic                   valid_d;
  logic [LEN_W-1:0]       len_o_d;
  logic [MAX_SYMBOLS-1:0] bits_o_d;
  logic                   err_o_d;
  logic                   word_gap_d;
  logic                   overrun_d;
  logic                   busy_d;

  logic                   sym_c;
  logic                   is_dash_c;
  logic [MAX_SYMBOLS-1:0] dash_bits_c;
  logic                   xfer_c;
  logic                   gap_hit_c;

  assign is_dash_c   = (morse_signal == SIG_DASH);
  assign sym_c       = (morse_signal == SIG_DOT) || is_dash_c;
  assign dash_bits_c = MAX_SYMBOLS'(is_dash_c);
  assign xfer_c      = sym_valid && sym_ready;
  assign gap_hit_c   = (cnt_q == LG_C);

`ifdef MORSE_ASCII_DECODE_EN
  logic [7:0] ascii_c;
  logic [7:0] ascii_d;

  morse_ascii_lut #(
    .MAX_SYMBOLS(MAX_SYMBOLS)
  ) u_lut (
    .len    (len_q),
    .bits   (bits_q),
    .err    (err_q),
    .ascii_c(ascii_c)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sym_c) state_d = COLLECT;
      COLLECT: if (!sym_c && gap_hit_c) state_d = PENDING;
      PENDING: if (xfer_c) state_d = sym_c ? COLLECT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    bits_d     = bits_q;
    err_d      = err_q;
    armed_d    = armed_q;
    valid_d    = sym_valid;
    len_o_d    = sym_len;
    bits_o_d   = sym_bits;
    err_o_d    = sym_err;
    word_gap_d = 1'b0;
    overrun_d  = overrun;
    busy_d     = (state_d != IDLE);
`ifdef MORSE_ASCII_DECODE_EN
    ascii_d    = char_ascii;
`endif

    // Free-running gap counter, saturating at the word gap.
    if (cnt_q < WG_C) cnt_d = cnt_q + CNT_W'(1);

    // Single word-gap pulse per emitted character.
    if (armed_q && (cnt_q == WG_C)) begin
      word_gap_d = 1'b1;
      armed_d    = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (sym_c) begin
          cnt_d  = '0;
          len_d  = LEN_W'(1);
          bits_d = dash_bits_c;
          err_d  = 1'b0;
        end
      end
      COLLECT: begin
        if (sym_c) begin
          cnt_d = '0;
          if (len_q < MAX_LEN) begin
            bits_d = bits_q | (dash_bits_c << len_q);
            len_d  = len_q + LEN_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end else if (gap_hit_c) begin
          valid_d  = 1'b1;
          len_o_d  = len_q;
          bits_o_d = bits_q;
          err_o_d  = err_q;
          armed_d  = 1'b1;
`ifdef MORSE_ASCII_DECODE_EN
          ascii_d  = ascii_c;
`endif
        end
      end
      PENDING: begin
        if (xfer_c) begin
          valid_d  = 1'b0;
          len_o_d  = '0;
          bits_o_d = '0;
          err_o_d  = 1'b0;
`ifdef MORSE_ASCII_DECODE_EN
          ascii_d  = 8'h00;
`endif
          if (sym_c) begin
            cnt_d  = '0;
            len_d  = LEN_W'(1);
            bits_d = dash_bits_c;
            err_d  = 1'b0;
          end else begin
            len_d  = '0;
            bits_d = '0;
            err_d  = 1'b0;
          end
        end else if (sym_c) begin
          overrun_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      len_q      <= '0;
      bits_q     <= '0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      sym_valid  <= 1'b0;
      sym_len    <= '0;
      sym_bits   <= '0;
      sym_err    <= 1'b0;
      word_gap   <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
`ifdef MORSE_ASCII_DECODE_EN
      char_ascii <= 8'h00;
`endif
    end else begin
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      bits_q     <= bits_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      sym_valid  <= valid_d;
      sym_len    <= len_o_d;
      sym_bits   <= bits_o_d;
      sym_err    <= err_o_d;
      word_gap   <= word_gap_d;
      overrun    <= overrun_d;
      busy       <= busy_d;
`ifdef MORSE_ASCII_DECODE_EN
      char_ascii <= ascii_d;
`endif
    end
  end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Directed self-checking bench for morse_symbol_sequencer (LETTER_GAP=20, WORD_GAP=50).
module tb_morse_symbol_sequencer;
  import morse_pkg::*;

  localparam int unsigned MS = 5;
  localparam int unsigned LG = 20;
  localparam int unsigned WG = 50;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    morse_signal = SIG_NONE;
  logic          sym_ready = 1'b1;
  logic          sym_valid;
  logic [2:0]    sym_len;
  logic [MS-1:0] sym_bits;
  logic          sym_err;
  logic          word_gap;
  logic          overrun;
  logic          busy;
`ifdef MORSE_ASCII_DECODE_EN
  logic [7:0]    char_ascii;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  morse_symbol_sequencer #(
    .MAX_SYMBOLS(MS),
    .LETTER_GAP (LG),
    .WORD_GAP   (WG),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .morse_signal(morse_signal),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_len     (sym_len),
    .sym_bits    (sym_bits),
    .sym_err     (sym_err),
    .word_gap    (word_gap),
    .overrun     (overrun),
    .busy        (busy)
`ifdef MORSE_ASCII_DECODE_EN
    ,
    .char_ascii  (char_ascii)
`endif
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a single-cycle code on the input.
  task automatic send(input logic [1:0] code);
    morse_signal = code;
    step();
    morse_signal = SIG_NONE;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    morse_signal = SIG_NONE;
    sym_ready    = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Edges until sym_valid rises, bounded at 100.
  task automatic wait_valid(output int n);
    n = 0;
    while (!sym_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({sym_valid, sym_len, sym_bits, sym_err, word_gap, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {sym_valid, sym_len, sym_bits, sym_err, word_gap, overrun, busy});
    end
    do_reset();
    morse_signal = 2'b11;
    repeat (3) step();
    morse_signal = SIG_NONE;
    repeat (25) step();
    checks++;
    if (busy !== 1'b0 || sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL code11_noop: got busy=%b valid=%b expected 0 0", busy, sym_valid);
    end
  endtask

  task automatic test_letter_a();
    int n;
    do_reset();
    send(SIG_DOT);
    repeat (4) step();
    send(SIG_DASH);
    wait_valid(n);
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL a_latency: got %0d edges expected 21", n);
    end
    checks++;
    if (sym_len !== 3'd2 || sym_bits !== 5'b00010 || sym_err !== 1'b0) begin
      errors++;
      $display("FAIL a_payload: got len=%0d bits=%b err=%b expected 2 00010 0",
               sym_len, sym_bits, sym_err);
    end
`ifdef MORSE_ASCII_DECODE_EN
    checks++;
    if (char_ascii !== 8'h41) begin
      errors++;
      $display("FAIL a_ascii: got %h expected 41", char_ascii);
    end
`endif
    step();
    checks++;
    if (sym_valid !== 1'b0 || busy !== 1'b0 || sym_len !== 3'd0) begin
      errors++;
      $display("FAIL a_after_xfer: got valid=%b busy=%b len=%0d expected 0 0 0",
               sym_valid, busy, sym_len);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(SIG_DOT);
      if (i < 5) repeat (2) step();
    end
    wait_valid(n);
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL ovf_latency: got %0d edges expected 21", n);
    end
    checks++;
    if (sym_len !== 3'd5 || sym_bits !== 5'b00000 || sym_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_payload: got len=%0d bits=%b err=%b expected 5 00000 1",
               sym_len, sym_bits, sym_err);
    end
`ifdef MORSE_ASCII_DECODE_EN
    checks++;
    if (char_ascii !== 8'h3F) begin
      errors++;
      $display("FAIL ovf_ascii: got %h expected 3f", char_ascii);
    end
`endif
    step();
    checks++;
    if (sym_err !== 1'b0 || sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err_clear: got err=%b valid=%b expected 0 0", sym_err, sym_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int unstable;
    int spurious;
    do_reset();
    sym_ready = 1'b0;
    send(SIG_DASH);
    wait_valid(n);
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL bp_latency: got %0d edges expected 21", n);
    end
    unstable = 0;
    for (int i = 0; i < 30; i++) begin
      morse_signal = (i == 10) ? SIG_DASH : SIG_NONE;
      step();
      if (sym_valid !== 1'b1 || sym_len !== 3'd1 || sym_bits !== 5'b00001 ||
          sym_err !== 1'b0 || busy !== 1'b1) unstable++;
    end
    morse_signal = SIG_NONE;
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun: got %b expected 1", overrun);
    end
    sym_ready = 1'b1;
    step();
    checks++;
    if (sym_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b busy=%b overrun=%b expected 0 0 1",
               sym_valid, busy, overrun);
    end
    spurious = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sym_valid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL bp_dropped: got %0d valid cycles expected 0", spurious);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    send(SIG_DOT);
    wait_valid(n);
    checks++;
    if (n != 21 || sym_len !== 3'd1 || sym_bits !== 5'b00000) begin
      errors++;
      $display("FAIL b2b_first: got n=%0d len=%0d bits=%b expected 21 1 00000",
               n, sym_len, sym_bits);
    end
`ifdef MORSE_ASCII_DECODE_EN
    checks++;
    if (char_ascii !== 8'h45) begin
      errors++;
      $display("FAIL b2b_ascii_e: got %h expected 45", char_ascii);
    end
`endif
    send(SIG_DASH);
    checks++;
    if (sym_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got valid=%b busy=%b expected 0 1", sym_valid, busy);
    end
    wait_valid(n);
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL b2b_latency: got %0d edges expected 21", n);
    end
    checks++;
    if (sym_len !== 3'd1 || sym_bits !== 5'b00001 || sym_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got len=%0d bits=%b err=%b overrun=%b expected 1 00001 0 0",
               sym_len, sym_bits, sym_err, overrun);
    end
`ifdef MORSE_ASCII_DECODE_EN
    checks++;
    if (char_ascii !== 8'h54) begin
      errors++;
      $display("FAIL b2b_ascii_t: got %h expected 54", char_ascii);
    end
`endif
  endtask

  task automatic test_word_gap();
    int pulses;
    int first;
    do_reset();
    send(SIG_DOT);
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (word_gap === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL wg_count: got %0d pulses expected 1", pulses);
    end
    checks++;
    if (first != 51) begin
      errors++;
      $display("FAIL wg_timing: got edge %0d expected 51", first);
    end
  endtask

  task automatic test_reset_mid();
    int spurious;
    do_reset();
    send(SIG_DASH);
    repeat (2) step();
    send(SIG_DOT);
    repeat (2) step();
    send(SIG_DASH);
    step();
    checks++;
    if (busy !== 1'b1 || sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_collect: got busy=%b valid=%b expected 1 0", busy, sym_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sym_valid, sym_len, sym_bits, sym_err, word_gap, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL rm_async: got %b expected all zero",
               {sym_valid, sym_len, sym_bits, sym_err, word_gap, overrun, busy});
    end
    #2;
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sym_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rm_stale: got %0d active cycles expected 0", spurious);
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_word_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
